// File: rtl/alu_result_stage.sv
// Registered 4-op ALU result stage: accepted operand sets are evaluated and
// buffered in a small in-order FIFO, with an accumulator for chained operations.
module alu_result_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [1:0]       in_op,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_zero,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] acc_q
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = WIDTH + 2;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   alu_r;
    logic [EW-1:0]    entry_d;
    logic [EW-1:0]    head;
    logic             push, pop;

    // Returns {cout, result}; only ADD produces a carry.
    function automatic logic [WIDTH:0] alu_eval(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin);
        logic [WIDTH:0] r;
        case (op)
            2'b00:   r = {1'b0, a & b};
            2'b01:   r = {1'b0, a | b};
            2'b10:   r = {1'b0, a ^ b};
            default: r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        endcase
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        in_ready  = !reset && (count_q < CW'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;

        op_a    = in_acc ? acc_q : in_a;
        alu_r   = alu_eval(in_op, op_a, in_b, in_cin);
        entry_d = {alu_r[WIDTH-1:0], alu_r[WIDTH], (alu_r[WIDTH-1:0] == '0)};

        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        acc_d  = push ? alu_r[WIDTH-1:0] : acc_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Head is read straight from storage; empty FIFO presents zeros.
        head       = mem_q[rptr_q];
        out_result = out_valid ? head[EW-1:2] : '0;
        out_cout   = out_valid ? head[1] : 1'b0;
        out_zero   = out_valid ? head[0] : 1'b0;
        count      = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            acc_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= entry_d;
        end
    end

endmodule
